// File: rtl/alsu_sched_pkg.sv
// Shared types and constants for the ALSU command scheduler.
// Command word layout: [11:9] opcode, [8:6] A, [5:3] B, [2] cin, [1] serial_in, [0] direction.
package alsu_sched_pkg;

  localparam int ALSU_LAT_DEF = 2;

  localparam int CMD_W  = 12;
  localparam int OP_HI  = 11;
  localparam int OP_LO  = 9;
  localparam int A_HI   = 8;
  localparam int A_LO   = 6;
  localparam int B_HI   = 5;
  localparam int B_LO   = 3;
  localparam int CIN_B  = 2;
  localparam int SI_B   = 1;
  localparam int DIR_B  = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alsu_sched_arb.sv
// Two-way round-robin arbiter. The last-grant register is only advanced
// when the scheduler retires a transaction, so a stalled winner keeps priority.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       upd,
  input  logic       upd_idx,
  output logic [1:0] gnt
);

  logic last_q, last_d;

  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (en) begin
      if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
      else              gnt = req;
    end
    if (upd) last_d = upd_idx;
  end

  // Reset value 1 lets requester 0 win the first tie.
  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/alsu_sched.sv
// Schedules commands from two requesters onto one ALSU, waits out its fixed
// latency, and presents the result through a valid/ready response port.
module alsu_sched
  import alsu_sched_pkg::*;
#(
  parameter int ALSU_LAT = ALSU_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [11:0] req0_cmd,
  input  logic [11:0] req1_cmd,
  output logic [2:0]  alsu_A,
  output logic [2:0]  alsu_B,
  output logic [2:0]  alsu_opcode,
  output logic        alsu_cin,
  output logic        alsu_serial_in,
  output logic        alsu_direction,
  output logic        alsu_red_op_A,
  output logic        alsu_red_op_B,
  output logic        alsu_bypass_A,
  output logic        alsu_bypass_B,
  input  logic [5:0]  alsu_out,
  input  logic [15:0] alsu_leds,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [5:0]  rsp_data,
  output logic        rsp_err
);

  localparam int CNT_W = $clog2(ALSU_LAT + 1) + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CMD_W-1:0]   cmd_q, cmd_d;
  logic               gid_q, gid_d;
  logic               rsp_id_q, rsp_id_d;
  logic [5:0]         rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic [1:0]         gnt;
  logic               arb_en;
  logic               arb_upd;

  assign arb_en = (state_q == S_IDLE) && !rst;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .en      (arb_en),
    .upd     (arb_upd),
    .upd_idx (gid_q),
    .gnt     (gnt)
  );

  assign req_ready = gnt;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    gid_d      = gid_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    arb_upd    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|gnt) begin
          cmd_d   = gnt[1] ? req1_cmd : req0_cmd;
          gid_d   = gnt[1];
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(ALSU_LAT)) begin
          rsp_data_d = alsu_out;
          rsp_err_d  = (alsu_leds != 16'h0000);
          rsp_id_d   = gid_q;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          arb_upd = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cmd_q      <= '0;
      gid_q      <= 1'b0;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      gid_q      <= gid_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // The ALSU is driven straight from the held command so it stays put until the next accept.
  assign alsu_opcode    = cmd_q[OP_HI:OP_LO];
  assign alsu_A         = cmd_q[A_HI:A_LO];
  assign alsu_B         = cmd_q[B_HI:B_LO];
  assign alsu_cin       = cmd_q[CIN_B];
  assign alsu_serial_in = cmd_q[SI_B];
  assign alsu_direction = cmd_q[DIR_B];
  assign alsu_red_op_A  = 1'b0;
  assign alsu_red_op_B  = 1'b0;
  assign alsu_bypass_A  = 1'b0;
  assign alsu_bypass_B  = 1'b0;

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alsu_sched.sv
// Bench for alsu_sched: a behavioural ALSU with fixed latency sits behind the DUT,
// and a transaction-level model predicts handshakes and responses every cycle.
module tb_alsu_sched;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [11:0] req0_cmd, req1_cmd;
  logic [2:0]  alsu_A, alsu_B, alsu_opcode;
  logic        alsu_cin, alsu_serial_in, alsu_direction;
  logic        alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B;
  logic [5:0]  alsu_out;
  logic [15:0] alsu_leds;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [5:0]  rsp_data;

  alsu_sched #(.ALSU_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_cmd(req0_cmd), .req1_cmd(req1_cmd),
    .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_opcode(alsu_opcode),
    .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in), .alsu_direction(alsu_direction),
    .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
    .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
    .alsu_out(alsu_out), .alsu_leds(alsu_leds),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // {err, data} of an ALSU operation, invalid opcodes flag err with data 0.
  function automatic logic [6:0] alsu_fn(input logic [11:0] c);
    logic [2:0] op, a, b;
    logic cin, si, dir;
    {op, a, b, cin, si, dir} = c;
    case (op)
      3'd0:    return {4'b0, a & b};
      3'd1:    return {4'b0, a ^ b};
      3'd2:    return {1'b0, 6'(a) + 6'(b) + 6'(cin)};
      3'd3:    return {1'b0, 6'(a) * 6'(b)};
      3'd4:    return {4'b0, (dir ? {a[1:0], si} : {si, a[2:1]})};
      3'd5:    return {4'b0, (dir ? {a[1:0], a[2]} : {a[0], a[2:1]})};
      default: return 7'h40;
    endcase
  endfunction

  logic [6:0] alsu_pipe [LAT];
  always @(posedge clk) begin
    alsu_pipe[0] <= alsu_fn({alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_serial_in, alsu_direction});
    for (int i = 1; i < LAT; i++) alsu_pipe[i] <= alsu_pipe[i-1];
  end
  assign alsu_out  = alsu_pipe[LAT-1][5:0];
  assign alsu_leds = alsu_pipe[LAT-1][6] ? 16'hFFFF : 16'h0000;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Transaction model state
  bit         busy = 0;
  int         since = 0;
  bit         last_g = 1;
  logic [11:0] alsu_cmd = '0;
  bit         exp_id;
  logic [6:0] exp_rsp;
  int         cyc = 0;
  int         acc_cyc = 0;
  logic [1:0] acc;
  bit         obs_vld;
  logic [7:0] obs_rsp;
  logic [1:0] obs_rdy;
  int         obs_cyc;

  function automatic logic [1:0] pick(input logic [1:0] v, input bit last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  // Check outputs at the falling edge, then advance the model across the next rising edge.
  task automatic tick();
    logic [1:0] er;
    bit ev;
    @(negedge clk);
    er = (rst || busy) ? 2'b00 : pick(req_valid, last_g);
    ev = busy && (since >= LAT + 1);
    chk("req_ready", req_ready, er);
    chk("rsp_valid", rsp_valid, ev);
    if (ev) chk("rsp", {rsp_id, rsp_err, rsp_data}, {exp_id, exp_rsp});
    chk("alsu_drv", {alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_serial_in, alsu_direction,
                     alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B}, {alsu_cmd, 4'b0});
    obs_vld = rsp_valid;
    obs_rsp = {rsp_id, rsp_err, rsp_data};
    obs_rdy = req_ready;
    obs_cyc = cyc;
    acc = 2'b00;
    if (rst) begin
      busy = 0; since = 0; last_g = 1; alsu_cmd = '0;
    end else if (!busy && er != 2'b00) begin
      acc = er; busy = 1; since = 0; last_g = er[1];
      alsu_cmd = er[1] ? req1_cmd : req0_cmd;
      exp_id = er[1];
      exp_rsp = alsu_fn(alsu_cmd);
      acc_cyc = cyc + 1;
    end else if (busy) begin
      if (ev && rsp_ready) busy = 0;
      else since++;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_acc(input int g);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (acc[g]) break;
    end
    chk("acc_timeout", acc[g], 1);
    req_valid[g] = 1'b0;
  endtask

  task automatic send(input int g, input logic [11:0] c);
    if (g == 0) req0_cmd = c; else req1_cmd = c;
    req_valid[g] = 1'b1;
    wait_acc(g);
  endtask

  task automatic wait_rsp(output logic [7:0] r, output int lat);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (obs_vld) break;
    end
    chk("rsp_timeout", obs_vld, 1);
    r = obs_rsp;
    lat = obs_cyc - acc_cyc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_out", {alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_serial_in, alsu_direction,
                    alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B,
                    rsp_valid, rsp_id, rsp_data, rsp_err}, 0);
    chk("rst_rdy", req_ready, 2'b00);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r, held;
    int lat;
    bit seen;
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
    req0_cmd = '0; req1_cmd = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    req_valid = 2'b00;

    // Single ADD 3+2 from requester 0
    send(0, {3'd2, 3'd3, 3'd2, 1'b0, 1'b0, 1'b0});
    wait_rsp(r, lat);
    chk("single_lat", lat, 3);
    chk("single_rsp", r, {1'b0, 1'b0, 6'd5});

    // Tie after reset: requester 0 first
    do_reset();
    req0_cmd = {3'd0, 3'd7, 3'd5, 3'b000};
    req1_cmd = {3'd3, 3'd3, 3'd3, 3'b000};
    req_valid = 2'b11;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (acc != 2'b00) break;
    end
    chk("tie_first", acc, 2'b01);
    req_valid[0] = 1'b0;
    wait_rsp(r, lat);
    chk("tie_rsp0", r, {1'b0, 1'b0, 6'd5});
    wait_acc(1);
    wait_rsp(r, lat);
    chk("tie_rsp1", r, {1'b1, 1'b0, 6'd9});

    // Backpressure with the other requester waiting
    rsp_ready = 1'b0;
    req1_cmd = {3'd2, 3'd7, 3'd7, 3'b100};
    req_valid[1] = 1'b1;
    send(0, {3'd1, 3'd6, 3'd3, 3'b000});
    wait_rsp(r, lat);
    chk("bp_rsp", r, {1'b0, 1'b0, 6'd5});
    held = r;
    repeat (10) begin
      tick();
      chk("bp_vld", obs_vld, 1);
      chk("bp_hold", obs_rsp, held);
      chk("bp_rdy", obs_rdy, 2'b00);
    end
    rsp_ready = 1'b1;
    wait_acc(1);
    wait_rsp(r, lat);
    chk("bp_next", r, {1'b1, 1'b0, 6'd15});

    // Invalid opcode from requester 1
    send(1, {3'd6, 3'd1, 3'd2, 3'b000});
    wait_rsp(r, lat);
    chk("inv_rsp", r, {1'b1, 1'b1, 6'd0});

    // Reset in the middle of a transaction
    send(0, {3'd2, 3'd1, 3'd1, 3'b000});
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      tick();
      seen |= obs_vld;
    end
    chk("mid_novld", seen, 0);
    send(0, {3'd3, 3'd7, 3'd7, 3'b000});
    wait_rsp(r, lat);
    chk("mid_after", r, {1'b0, 1'b0, 6'd49});
    chk("mid_lat", lat, 3);

    // Randomized traffic, the model checks every cycle
    for (int i = 0; i < 800; i++) begin
      rsp_ready = ($urandom % 4) != 0;
      rst = ($urandom % 150) == 0;
      if (!req_valid[0] && ($urandom % 3) == 0) begin
        req0_cmd = 12'($urandom);
        req_valid[0] = 1'b1;
      end
      if (!req_valid[1] && ($urandom % 3) == 0) begin
        req1_cmd = 12'($urandom);
        req_valid[1] = 1'b1;
      end
      tick();
      req_valid = req_valid & ~acc;
    end
    rst = 1'b0; rsp_ready = 1'b1; req_valid = 2'b00;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alsu_sched.md
ALSU_SCHED -- requirements
Module: alsu_sched

Interface
REQ-001 Parameter ALSU_LAT, default 2, SHALL mean clock edges from ALSU input change to registered ALSU out valid.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  2  per-requester command valid, bit i = requester i.
REQ-005 req_ready  output  2  per-requester accept; at most one bit high.
REQ-006 req0_cmd  input  12  requester 0 command: [11:9] opcode, [8:6] A, [5:3] B, [2] cin, [1] serial_in, [0] direction.
REQ-007 req1_cmd  input  12  requester 1 command, same packing.
REQ-008 alsu_A, alsu_B, alsu_opcode  output  3 each  ALSU operand/opcode drive.
REQ-009 alsu_cin, alsu_serial_in, alsu_direction  output  1 each  ALSU control drive.
REQ-010 alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B  output  1 each  tied 0.
REQ-011 alsu_out  input  6  ALSU result.
REQ-012 alsu_leds  input  16  ALSU invalid-operation indicator.
REQ-013 rsp_valid  output  1  result available; rsp_ready  input  1  consumer accept.
REQ-014 rsp_id  output  1  requester index; rsp_data  output  6  result; rsp_err  output  1  invalid op.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, RESP.
REQ-016 IDLE: req_ready[g] SHALL be high combinationally for granted g when req_valid[g]=1 and rst=0; a command is accepted on an edge with req_valid[g]&req_ready[g].
REQ-017 Arbitration SHALL be round-robin: single valid wins; both valid -> requester not granted last.
REQ-018 On accept, the command and grant index SHALL be registered, alsu_* outputs SHALL take the command fields from the next cycle, counter cleared, state -> WAIT.
REQ-019 alsu_* outputs SHALL hold their value from accept until the next accept.
REQ-020 WAIT: counter increments each edge; at counter==ALSU_LAT the edge SHALL capture rsp_data=alsu_out, rsp_err=(alsu_leds!=0), rsp_id=grant, and -> RESP.
REQ-021 rsp_valid SHALL rise exactly ALSU_LAT+1 edges after the accept edge.
REQ-022 RESP: rsp_valid, rsp_id, rsp_data, rsp_err SHALL hold stable until rsp_valid&rsp_ready; that edge -> IDLE, last-grant updated.
REQ-023 req_ready SHALL be 0 in WAIT and RESP; requests SHALL NOT be lost, only stalled.
REQ-024 Minimum spacing between accepts SHALL be ALSU_LAT+3 cycles when rsp_ready is held high.
REQ-025 Opcodes 6/7 SHALL be forwarded unchanged; error detection relies solely on alsu_leds.

Reset
REQ-026 rst high at an edge SHALL force IDLE, counter 0, last-grant=1 (requester 0 wins first tie).
REQ-027 During and after reset: req_ready=0 while rst=1, all alsu_* outputs 0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0.
REQ-028 Reset mid-transaction SHALL drop it with no response.

Structure
REQ-029 Package alsu_sched_pkg SHALL hold the state enum, cmd field offsets and ALSU_LAT default.
REQ-030 Sub-module rr_arb2 (2-way round-robin, grant + last-grant register) SHALL implement REQ-017.

Verification (bench instantiates alsu_sched driving the real ALSU)
REQ-031 Reset: rst=1 two cycles -> all outputs 0, req_ready=0 with req_valid=2'b11.
REQ-032 Single op: req0 ADD A=3 B=2 cin=0 -> rsp_valid exactly 3 cycles after accept, rsp_id=0, rsp_data=5, rsp_err=0.
REQ-033 Tie: both valid, req0 AND 7&5, req1 MULT 3*3 -> req0 served first (data 5), then req1 (data 9, id 1).
REQ-034 Backpressure: rsp_ready=0 for 10 cycles -> response held stable, req_ready stays 0, then completes on rsp_ready=1.
REQ-035 Invalid: req1 opcode 6 -> rsp_err=1, rsp_id=1.
REQ-036 Mid-op reset: rst at WAIT cycle 1 -> no rsp_valid; next command completes normally.
